bus_arbiter2: RTL and testbench

BUS_ARBITER2 -- requirements
Module: bus_arbiter2

---
 rtl/bus_arbiter2.sv | 162 ++++++++++++++++
 tb/tb_bus_arbiter2.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : bus_arbiter2
// Purpose  : Two-requester round-robin bus arbiter with stall watchdog.
// Revision : 1.0
// ----------------------------------------------------------------------------
module bus_arbiter2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] m0_addr,
    input  logic [2:0]    m0_size,
    input  logic          m0_valid,
    input  logic          m0_write,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ready,
    input  logic [AW-1:0] m1_addr,
    input  logic [2:0]    m1_size,
    input  logic          m1_valid,
    input  logic          m1_write,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ready,
    output logic [AW-1:0] s_addr,
    output logic [2:0]    s_size,
    output logic          s_valid,
    output logic          s_write,
    output logic [DW-1:0] s_wdata,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_ready,
    output logic [1:0]    grant,
    output logic          timeout_err
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_BUSY0   = 2'd1;
    localparam logic [1:0] c_BUSY1   = 2'd2;
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       r_last;
    logic [7:0] r_cnt;
    logic       r_timeout_err;

    logic w_busy0;
    logic w_busy1;
    logic w_busy;
    logic w_own_valid;
    logic w_wdog;
    logic w_done;
    logic w_enter_busy;

    assign w_busy0     = (r_state == c_BUSY0);
    assign w_busy1     = (r_state == c_BUSY1);
    assign w_busy      = w_busy0 | w_busy1;
    assign w_own_valid = w_busy1 ? m1_valid : m0_valid;

    // A dropped request is an abort, so the watchdog only fires on a live request.
    assign w_wdog = (TIMEOUT != 0) && w_busy && w_own_valid && !s_ready
                    && (r_cnt == c_TIMEOUT);
    assign w_done = w_busy && (s_ready || w_wdog);
    assign w_enter_busy = (w_next_state != c_IDLE) && ((r_state == c_IDLE) || w_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (m0_valid && (!m1_valid || r_last)) begin
                    w_next_state = c_BUSY0;
                end else if (m1_valid) begin
                    w_next_state = c_BUSY1;
                end
            end
            c_BUSY0: begin
                if (w_done) begin
                    w_next_state = m1_valid ? c_BUSY1 : c_IDLE;
                end else if (!m0_valid) begin
                    w_next_state = c_IDLE;
                end
            end
            c_BUSY1: begin
                if (w_done) begin
                    w_next_state = m0_valid ? c_BUSY0 : c_IDLE;
                end else if (!m1_valid) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last        <= 1'b1;
            r_cnt         <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_done) begin
                r_last <= w_busy1;
            end
            if (w_wdog) begin
                r_timeout_err <= 1'b1;
            end
            if (w_enter_busy) begin
                r_cnt <= 8'd0;
            end else if (w_busy && !s_ready) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        s_addr   = '0;
        s_size   = '0;
        s_valid  = 1'b0;
        s_write  = 1'b0;
        s_wdata  = '0;
        m0_rdata = '0;
        m0_ready = 1'b0;
        m1_rdata = '0;
        m1_ready = 1'b0;
        case (r_state)
            c_BUSY0: begin
                s_addr   = m0_addr;
                s_size   = m0_size;
                s_valid  = m0_valid & ~w_wdog;
                s_write  = m0_write;
                s_wdata  = m0_wdata;
                m0_rdata = w_wdog ? '0 : s_rdata;
                m0_ready = s_ready | w_wdog;
            end
            c_BUSY1: begin
                s_addr   = m1_addr;
                s_size   = m1_size;
                s_valid  = m1_valid & ~w_wdog;
                s_write  = m1_write;
                s_wdata  = m1_wdata;
                m1_rdata = w_wdog ? '0 : s_rdata;
                m1_ready = s_ready | w_wdog;
            end
            default: ;
        endcase
    end

    assign grant       = {w_busy1, w_busy0};
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_bus_arbiter2
// Purpose  : Scoreboard bench for bus_arbiter2 (TIMEOUT=4).
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_bus_arbiter2;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    typedef struct {
        logic          port;
        logic [DW-1:0] rdata;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [AW-1:0] m0_addr, m1_addr, s_addr;
    logic [2:0]    m0_size, m1_size, s_size;
    logic          m0_valid, m1_valid, s_valid;
    logic          m0_write, m1_write, s_write;
    logic [DW-1:0] m0_wdata, m1_wdata, s_wdata;
    logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
    logic          m0_ready, m1_ready, s_ready;
    logic [1:0]    grant;
    logic          timeout_err;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic [1:0] grant_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_size(m0_size), .m0_valid(m0_valid), .m0_write(m0_write),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_addr(m1_addr), .m1_size(m1_size), .m1_valid(m1_valid), .m1_write(m1_write),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .s_addr(s_addr), .s_size(s_size), .s_valid(s_valid), .s_write(s_write),
        .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ready(s_ready),
        .grant(grant), .timeout_err(timeout_err)
    );

    task automatic clear_inputs();
        m0_addr = '0; m0_size = '0; m0_valid = 1'b0; m0_write = 1'b0; m0_wdata = '0;
        m1_addr = '0; m1_size = '0; m1_valid = 1'b0; m1_write = 1'b0; m1_wdata = '0;
        s_rdata = '0; s_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({grant, timeout_err, s_valid, m0_ready, m1_ready} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 000000", {grant, timeout_err, s_valid, m0_ready, m1_ready});
        end
        checks++;
        if ({s_addr, s_wdata, m0_rdata, m1_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_data: got addr=%h wdata=%h r0=%h r1=%h expected all 0", s_addr, s_wdata, m0_rdata, m1_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        exp_t e;
        @(negedge clk);
        m0_addr = 32'h1000; m0_size = 3'd2; m0_write = 1'b0; m0_valid = 1'b1;
        exp_q.push_back('{1'b0, 32'hCAFE_0001});
        #1;
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("FAIL single_grant_lat: got %b expected 00", grant);
        end
        @(negedge clk); #1;
        checks++;
        if (grant !== 2'b01 || s_valid !== 1'b1 || s_addr !== 32'h1000 || s_size !== 3'd2 || s_write !== 1'b0) begin
            failures++;
            $display("FAIL single_grant: got grant=%b valid=%b addr=%h size=%0d expected 01 1 1000 2", grant, s_valid, s_addr, s_size);
        end
        @(negedge clk); #1;
        checks++;
        if (m0_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_early_ready: got %b expected 0", m0_ready);
        end
        @(negedge clk);
        s_ready = 1'b1; s_rdata = 32'hCAFE_0001;
        #1;
        e = exp_q.pop_front();
        checks++;
        if (m0_ready !== 1'b1 || m0_rdata !== e.rdata) begin
            failures++;
            $display("FAIL single_done: got ready=%b rdata=%h expected 1 %h", m0_ready, m0_rdata, e.rdata);
        end
        checks++;
        if (m1_ready !== 1'b0 || m1_rdata !== '0) begin
            failures++;
            $display("FAIL single_other: got ready=%b rdata=%h expected 0 0", m1_ready, m1_rdata);
        end
        @(negedge clk);
        s_ready = 1'b0;
        #1;
        checks++;
        if (grant !== 2'b00 || m0_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: got grant=%b ready=%b expected 00 0", grant, m0_ready);
        end
        m0_valid = 1'b0;
    endtask

    task automatic test_abort();
        exp_t e;
        @(negedge clk);
        m1_addr = 32'h2000; m1_write = 1'b1; m1_wdata = 32'h55; m1_valid = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (grant !== 2'b10 || s_addr !== 32'h2000 || s_wdata !== 32'h55 || s_write !== 1'b1) begin
            failures++;
            $display("FAIL abort_grant: got grant=%b addr=%h wdata=%h write=%b expected 10 2000 55 1", grant, s_addr, s_wdata, s_write);
        end
        @(negedge clk);
        m1_valid = 1'b0;
        #1;
        checks++;
        if (m1_ready !== 1'b0 || s_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_ready: got ready=%b s_valid=%b expected 0 0", m1_ready, s_valid);
        end
        @(negedge clk); #1;
        checks++;
        if (grant !== 2'b00 || m1_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: got grant=%b ready=%b expected 00 0", grant, m1_ready);
        end
        // last must still point at m0, so a tie now goes to m1
        m0_valid = 1'b1; m1_valid = 1'b1; m0_addr = 32'h1004; m1_addr = 32'h2004; m1_write = 1'b0;
        exp_q.push_back('{1'b1, 32'h1111_2222});
        @(negedge clk);
        s_ready = 1'b1; s_rdata = 32'h1111_2222;
        #1;
        checks++;
        if (grant !== 2'b10) begin
            failures++;
            $display("FAIL abort_last: got grant=%b expected 10", grant);
        end
        e = exp_q.pop_front();
        checks++;
        if (m1_ready !== 1'b1 || m1_rdata !== e.rdata || m0_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_follow: got ready=%b rdata=%h r0=%b expected 1 %h 0", m1_ready, m1_rdata, m0_ready, e.rdata);
        end
        m0_valid = 1'b0; m1_valid = 1'b0;
        @(negedge clk);
        s_ready = 1'b0;
    endtask

    task automatic test_contention();
        exp_t e;
        logic [1:0] eg;
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b1; m0_addr = 32'h10; m1_addr = 32'h20;
        grant_q = '{2'b01, 2'b10, 2'b01, 2'b10};
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("FAIL cont_release: got %b expected 00", grant);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_rdata = 32'hA5A5_0000 + 32'(i);
            exp_q.push_back('{1'(i % 2), 32'hA5A5_0000 + 32'(i)});
            #1;
            eg = grant_q.pop_front();
            e  = exp_q.pop_front();
            checks++;
            if (grant !== eg) begin
                failures++;
                $display("FAIL cont_grant[%0d]: got %b expected %b", i, grant, eg);
            end
            checks++;
            if ((e.port ? m1_ready : m0_ready) !== 1'b1 || (e.port ? m1_rdata : m0_rdata) !== e.rdata
                || (e.port ? m0_ready : m1_ready) !== 1'b0) begin
                failures++;
                $display("FAIL cont_data[%0d]: got r0=%b r1=%b d0=%h d1=%h expected owner m%0d data %h",
                         i, m0_ready, m1_ready, m0_rdata, m1_rdata, e.port, e.rdata);
            end
        end
        @(negedge clk);
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("FAIL cont_idle: got %b expected 00", grant);
        end
    endtask

    task automatic test_watchdog();
        exp_t e;
        @(negedge clk);
        m0_addr = 32'h3000; m0_write = 1'b1; m0_wdata = 32'hDEAD_BEEF; m0_valid = 1'b1;
        s_rdata = 32'h7777_7777;
        exp_q.push_back('{1'b0, 32'h0});
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); #1;
            checks++;
            if (grant !== 2'b01 || m0_ready !== 1'b0 || s_valid !== 1'b1 || s_addr !== 32'h3000
                || s_write !== 1'b1 || s_wdata !== 32'hDEAD_BEEF) begin
                failures++;
                $display("FAIL wdog_stall[%0d]: got grant=%b ready=%b valid=%b addr=%h expected 01 0 1 3000", k, grant, m0_ready, s_valid, s_addr);
            end
        end
        @(negedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if (m0_ready !== 1'b1 || m0_rdata !== e.rdata || s_valid !== 1'b0) begin
            failures++;
            $display("FAIL wdog_fire: got ready=%b rdata=%h s_valid=%b expected 1 %h 0", m0_ready, m0_rdata, s_valid, e.rdata);
        end
        @(negedge clk); #1;
        checks++;
        if (timeout_err !== 1'b1 || grant !== 2'b00) begin
            failures++;
            $display("FAIL wdog_err: got err=%b grant=%b expected 1 00", timeout_err, grant);
        end
        m0_valid = 1'b0; m0_write = 1'b0;
        @(negedge clk);
        m1_valid = 1'b1; m1_addr = 32'h2010;
        exp_q.push_back('{1'b1, 32'h4444});
        @(negedge clk);
        s_ready = 1'b1; s_rdata = 32'h4444;
        #1;
        e = exp_q.pop_front();
        checks++;
        if (m1_ready !== 1'b1 || m1_rdata !== e.rdata) begin
            failures++;
            $display("FAIL wdog_after: got ready=%b rdata=%h expected 1 %h", m1_ready, m1_rdata, e.rdata);
        end
        m1_valid = 1'b0;
        @(negedge clk);
        s_ready = 1'b0;
        #1;
        checks++;
        if (timeout_err !== 1'b1 || grant !== 2'b00) begin
            failures++;
            $display("FAIL wdog_sticky: got err=%b grant=%b expected 1 00", timeout_err, grant);
        end
    endtask

    task automatic test_corner();
        exp_t e;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL corner_clear: got err=%b expected 0", timeout_err);
        end
        m0_valid = 1'b1; m0_addr = 32'h3004;
        exp_q.push_back('{1'b0, 32'hBEEF_0005});
        repeat (5) @(negedge clk);
        s_ready = 1'b1; s_rdata = 32'hBEEF_0005;
        #1;
        e = exp_q.pop_front();
        checks++;
        if (m0_ready !== 1'b1 || m0_rdata !== e.rdata || s_valid !== 1'b1) begin
            failures++;
            $display("FAIL corner_done: got ready=%b rdata=%h s_valid=%b expected 1 %h 1", m0_ready, m0_rdata, s_valid, e.rdata);
        end
        m0_valid = 1'b0;
        @(negedge clk);
        s_ready = 1'b0;
        #1;
        checks++;
        if (timeout_err !== 1'b0 || grant !== 2'b00) begin
            failures++;
            $display("FAIL corner_noerr: got err=%b grant=%b expected 0 00", timeout_err, grant);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        m1_valid = 1'b1; m1_addr = 32'h2008; m1_wdata = 32'h1234;
        @(negedge clk); #1;
        checks++;
        if (grant !== 2'b10) begin
            failures++;
            $display("FAIL rmid_grant: got %b expected 10", grant);
        end
        #2;
        rst = 1'b1; s_ready = 1'b1; s_rdata = 32'h9999;
        #1;
        checks++;
        if ({grant, s_valid, m1_ready, m0_ready, timeout_err} !== 6'b0 || s_addr !== '0 || s_wdata !== '0 || m1_rdata !== '0) begin
            failures++;
            $display("FAIL rmid_async: got grant=%b valid=%b r1=%b addr=%h d1=%h expected all 0", grant, s_valid, m1_ready, s_addr, m1_rdata);
        end
        m0_valid = 1'b1; s_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("FAIL rmid_release: got %b expected 00", grant);
        end
        @(negedge clk); #1;
        checks++;
        if (grant !== 2'b01) begin
            failures++;
            $display("FAIL rmid_first: got %b expected 01", grant);
        end
        clear_inputs();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_abort();
        test_contention();
        test_watchdog();
        test_corner();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
